// File: rtl/shift_arbiter_16b.sv
// Two-port round-robin arbiter in front of the shared 16-bit barrel shifter.
// Each accepted request drives the shifter lines for one cycle, and the result
// is captured into a one-entry response register tagged with the winning port.
// A pair of saturating grant counters tracks how often each port is served.
module shift_arbiter_16b #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_in,
  input  logic [15:0]      req0_sh,
  input  logic             req0_sign,
  input  logic             req0_cont,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_in,
  input  logic [15:0]      req1_sh,
  input  logic             req1_sign,
  input  logic             req1_cont,
  output logic [15:0]      sh_in,
  output logic [15:0]      sh_amt,
  output logic             sh_sign,
  output logic             sh_cont,
  input  logic [15:0]      sh_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [15:0]      rsp_data,
  output logic [CNT_W-1:0] gnt0_cnt,
  output logic [CNT_W-1:0] gnt1_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic prio;
  logic sel;
  logic any_valid;
  logic slot_free;
  logic hs;

  // Pick the winner: preferred port if valid, else the other one. With no
  // valid request sel falls back to 0 so the shifter sees port 0's fields.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (prio) sel = req1_valid;
    else      sel = !req0_valid && req1_valid;
    slot_free  = !rsp_valid || rsp_ready;
    hs         = slot_free && any_valid;
    req0_ready = hs && !sel;
    req1_ready = hs && sel;
  end

  // Steer the winning port's fields onto the shifter.
  always_comb begin
    if (sel) begin
      sh_in   = req1_in;
      sh_amt  = req1_sh;
      sh_sign = req1_sign;
      sh_cont = req1_cont;
    end else begin
      sh_in   = req0_in;
      sh_amt  = req0_sh;
      sh_sign = req0_sign;
      sh_cont = req0_cont;
    end
  end

  // Response slot and round-robin pointer. A capture in the same cycle as a
  // drain simply overwrites the slot so back-to-back operation is sustained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 16'h0000;
      prio      <= 1'b0;
    end else if (hs) begin
      rsp_valid <= 1'b1;
      rsp_id    <= sel;
      rsp_data  <= sh_out;
      prio      <= !sel;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Per-port grant counters, pinned at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0_cnt <= '0;
      gnt1_cnt <= '0;
    end else begin
      if (req0_ready && gnt0_cnt != CNT_MAX) gnt0_cnt <= gnt0_cnt + CNT_ONE;
      if (req1_ready && gnt1_cnt != CNT_MAX) gnt1_cnt <= gnt1_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_shift_arbiter_16b.sv
// Bench for shift_arbiter_16b: directed cases plus a randomized run checked
// cycle by cycle against a transaction-level model. A second instance with
// 2-bit counters shares the stimulus to exercise counter saturation.
module tb_shift_arbiter_16b;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid, req1_valid, req0_sign, req1_sign, req0_cont, req1_cont;
  logic [15:0] req0_in, req1_in, req0_sh, req1_sh;
  logic rsp_ready;

  logic req0_ready, req1_ready, sh_sign, sh_cont, rsp_valid, rsp_id;
  logic [15:0] sh_in, sh_amt, sh_out, rsp_data;
  logic [7:0] gnt0_cnt, gnt1_cnt;

  logic b_req0_ready, b_req1_ready, b_sh_sign, b_sh_cont, b_rsp_valid, b_rsp_id;
  logic [15:0] b_sh_in, b_sh_amt, b_sh_out, b_rsp_data;
  logic [1:0] b_gnt0_cnt, b_gnt1_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Behaviour of the external shifter.
  function automatic logic [15:0] ref_shift(input logic [15:0] x, input logic [15:0] amt,
                                            input logic sg, input logic ct);
    int n;
    logic [15:0] r;
    n = (amt > 16'd31) ? 31 : int'(amt);
    if (!ct)      r = (n >= 16) ? 16'h0000 : 16'(x << n);
    else if (!sg) r = (n >= 16) ? 16'h0000 : 16'(x >> n);
    else          r = (n >= 16) ? {16{x[15]}} : 16'($signed(x) >>> n);
    return r;
  endfunction

  assign sh_out   = ref_shift(sh_in, sh_amt, sh_sign, sh_cont);
  assign b_sh_out = ref_shift(b_sh_in, b_sh_amt, b_sh_sign, b_sh_cont);

  shift_arbiter_16b #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in),
    .req0_sh(req0_sh), .req0_sign(req0_sign), .req0_cont(req0_cont),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in),
    .req1_sh(req1_sh), .req1_sign(req1_sign), .req1_cont(req1_cont),
    .sh_in(sh_in), .sh_amt(sh_amt), .sh_sign(sh_sign), .sh_cont(sh_cont),
    .sh_out(sh_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
  );

  shift_arbiter_16b #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_in(req0_in),
    .req0_sh(req0_sh), .req0_sign(req0_sign), .req0_cont(req0_cont),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_in(req1_in),
    .req1_sh(req1_sh), .req1_sign(req1_sign), .req1_cont(req1_cont),
    .sh_in(b_sh_in), .sh_amt(b_sh_amt), .sh_sign(b_sh_sign), .sh_cont(b_sh_cont),
    .sh_out(b_sh_out), .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(b_rsp_id), .rsp_data(b_rsp_data),
    .gnt0_cnt(b_gnt0_cnt), .gnt1_cnt(b_gnt1_cnt)
  );

  // Reference model state: preferred port, one-entry response slot, grant totals.
  int          m_prio;
  bit          m_valid;
  int          m_id;
  logic [15:0] m_data;
  int          m_cnt[2];
  bit          last_hs[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prio = 0; m_valid = 0; m_id = 0; m_data = 16'h0000;
    m_cnt[0] = 0; m_cnt[1] = 0;
    last_hs[0] = 0; last_hs[1] = 0;
  endtask

  // Called a little after a rising edge; asserts reset and checks the cleared state.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_gnt0", 32'(gnt0_cnt), 32'd0);
    chk("rst_gnt1", 32'(gnt1_cnt), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 32'(rsp_valid), 32'd0);
    chk("rst_hold_gnt0", 32'(gnt0_cnt), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: compare every output with the model at the falling edge,
  // then advance the model across the rising edge.
  task automatic step();
    bit v[2];
    bit sf, hs;
    int w;
    logic [15:0] f_in, f_sh;
    logic f_sg, f_ct;
    @(negedge clk);
    v[0] = req0_valid; v[1] = req1_valid;
    sf = !m_valid || rsp_ready;
    if (v[m_prio])       w = m_prio;
    else if (v[1-m_prio]) w = 1 - m_prio;
    else                 w = -1;
    hs = sf && (w >= 0);
    if (w == 1) begin f_in = req1_in; f_sh = req1_sh; f_sg = req1_sign; f_ct = req1_cont; end
    else        begin f_in = req0_in; f_sh = req0_sh; f_sg = req0_sign; f_ct = req0_cont; end
    chk("ready0", 32'(req0_ready), 32'(hs && w == 0));
    chk("ready1", 32'(req1_ready), 32'(hs && w == 1));
    chk("sh_in", 32'(sh_in), 32'(f_in));
    chk("sh_amt", 32'(sh_amt), 32'(f_sh));
    chk("sh_ctl", {30'd0, sh_sign, sh_cont}, {30'd0, f_sg, f_ct});
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("rsp_data", 32'(rsp_data), 32'(m_data));
    chk("gnt0", 32'(gnt0_cnt), 32'((m_cnt[0] > 255) ? 255 : m_cnt[0]));
    chk("gnt1", 32'(gnt1_cnt), 32'((m_cnt[1] > 255) ? 255 : m_cnt[1]));
    chk("sat_gnt0", 32'(b_gnt0_cnt), 32'((m_cnt[0] > 3) ? 3 : m_cnt[0]));
    chk("sat_gnt1", 32'(b_gnt1_cnt), 32'((m_cnt[1] > 3) ? 3 : m_cnt[1]));
    @(posedge clk);
    #1;
    last_hs[0] = hs && w == 0;
    last_hs[1] = hs && w == 1;
    if (hs) begin
      m_valid = 1; m_id = w; m_data = ref_shift(f_in, f_sh, f_sg, f_ct);
      m_prio = 1 - w; m_cnt[w]++;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic setp(input int p, input bit v, input logic [15:0] x, input logic [15:0] amt,
                      input bit sg, input bit ct);
    if (p == 0) begin
      req0_valid = v; req0_in = x; req0_sh = amt; req0_sign = sg; req0_cont = ct;
    end else begin
      req1_valid = v; req1_in = x; req1_sh = amt; req1_sign = sg; req1_cont = ct;
    end
  endtask

  function automatic logic [15:0] rand_amt();
    return ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 17));
  endfunction

  initial begin
    setp(0, 0, 16'h0, 16'h0, 0, 0);
    setp(1, 0, 16'h0, 16'h0, 0, 0);
    rsp_ready = 1'b0;
    model_reset();
    do_reset();

    // Reset state with no request: both readies low, shifter shows port 0.
    step();

    // Single port 0 left shift.
    rsp_ready = 1'b1;
    setp(0, 1, 16'h8001, 16'd1, 0, 0);
    step();
    setp(0, 0, 16'h0, 16'h0, 0, 0);
    chk("p0_valid", 32'(rsp_valid), 32'd1);
    chk("p0_id", 32'(rsp_id), 32'd0);
    chk("p0_data", 32'(rsp_data), 32'h0002);
    chk("p0_gnt", 32'(gnt0_cnt), 32'd1);

    // Port 1 arithmetic and logical right shifts.
    setp(1, 1, 16'h8000, 16'd3, 1, 1);
    step();
    chk("p1_sra_data", 32'(rsp_data), 32'hF000);
    chk("p1_sra_id", 32'(rsp_id), 32'd1);
    setp(1, 1, 16'h8000, 16'd4, 0, 1);
    step();
    chk("p1_srl_data", 32'(rsp_data), 32'h0800);
    setp(1, 0, 16'h0, 16'h0, 0, 0);

    // Saturating amounts.
    setp(0, 1, 16'h1234, 16'h0100, 0, 0);
    step();
    chk("sat_sll", 32'(rsp_data), 32'h0000);
    setp(0, 1, 16'h8000, 16'h0100, 1, 1);
    step();
    chk("sat_sra", 32'(rsp_data), 32'hFFFF);
    setp(0, 0, 16'h0, 16'h0, 0, 0);
    step();
    chk("drain", 32'(rsp_valid), 32'd0);

    // Contention from a fresh reset: grants alternate 0,1,0,1 back-to-back.
    do_reset();
    rsp_ready = 1'b1;
    setp(0, 1, 16'h0003, 16'd2, 0, 0);
    setp(1, 1, 16'h0030, 16'd1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("cont_valid", 32'(rsp_valid), 32'd1);
      chk("cont_id", 32'(rsp_id), 32'(i % 2));
    end
    chk("cont_gnt0", 32'(gnt0_cnt), 32'd2);
    chk("cont_gnt1", 32'(gnt1_cnt), 32'd2);

    // Backpressure: slot held, no readies, data stable; then port 0 resumes.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'h0018);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_resume_id", 32'(rsp_id), 32'd0);
    chk("bp_resume_data", 32'(rsp_data), 32'h000C);
    chk("bp_resume_gnt0", 32'(gnt0_cnt), 32'd3);

    // Reset with a response pending and requests still presented.
    rsp_ready = 1'b0;
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    do_reset();
    rsp_ready = 1'b1;
    step();
    chk("post_rst_id", 32'(rsp_id), 32'd0);
    setp(1, 0, 16'h0, 16'h0, 0, 0);

    // Counter saturation: 5 port 0 grants total (one already taken).
    for (int i = 0; i < 4; i++) step();
    chk("sat_cnt2", 32'(b_gnt0_cnt), 32'd3);
    chk("sat_cnt8", 32'(gnt0_cnt), 32'd5);

    // Randomized traffic obeying the hold-until-accepted rule.
    for (int i = 0; i < 3000; i++) begin
      if (!(req0_valid && !last_hs[0]))
        setp(0, $urandom_range(0, 9) < 6, 16'($urandom), rand_amt(),
             1'($urandom), 1'($urandom));
      if (!(req1_valid && !last_hs[1]))
        setp(1, $urandom_range(0, 9) < 6, 16'($urandom), rand_amt(),
             1'($urandom), 1'($urandom));
      rsp_ready = $urandom_range(0, 9) < 7;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
